// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, default widths and the pipeline bubble encoding.
package cpu_pkg;

  localparam int RW  = 5;
  localparam int OPW = 6;

  localparam logic [OPW-1:0] OP_NOP = 6'b000000;
  localparam logic [OPW-1:0] OP_J   = 6'b000010;
  localparam logic [OPW-1:0] OP_BEQ = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE = 6'b000101;

  // A bubble writes nothing, stores nothing and targets r0, so it can never
  // match a source register in the forwarding or load-use compare.
  localparam logic           BUBBLE_WREG    = 1'b0;
  localparam logic           BUBBLE_WMEM    = 1'b0;
  localparam logic           BUBBLE_REG2REG = 1'b1;
  localparam logic [RW-1:0]  BUBBLE_RD      = '0;
  localparam logic [OPW-1:0] BUBBLE_OP      = OP_NOP;

endpackage

// File: rtl/sat_counter.sv
// Event counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_full;

  assign w_full  = &r_count;
  assign o_count = r_count;

  // Count enabled events until the counter is full; clear wins over counting.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_count <= '0;
    end else if (i_inc && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_pipe_regs.sv
// E/M/W control pipeline registers with stall/squash bubble insertion,
// PC and IF/ID strobes, and stall/flush event counters.
module hazard_pipe_regs #(
  parameter int RW    = cpu_pkg::RW,
  parameter int OPW   = cpu_pkg::OPW,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             STALL,
  input  logic             Condep,
  input  logic             dWreg,
  input  logic             dReg2reg,
  input  logic             dWmem,
  input  logic [RW-1:0]    dRd,
  input  logic [OPW-1:0]   dOp,
  output logic             eWreg,
  output logic             eReg2reg,
  output logic             eWmem,
  output logic [RW-1:0]    eRd,
  output logic [OPW-1:0]   eOp,
  output logic             mWreg,
  output logic             mReg2reg,
  output logic             mWmem,
  output logic [RW-1:0]    mRd,
  output logic             wWreg,
  output logic             wReg2reg,
  output logic [RW-1:0]    wRd,
  output logic             PcEn,
  output logic             IfIdEn,
  output logic             IfIdFlush,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  import cpu_pkg::*;

  logic           w_squash;
  logic           w_bubble_e;
  logic           w_stall_evt;

  logic           r_e_wreg, r_e_reg2reg, r_e_wmem;
  logic [RW-1:0]  r_e_rd;
  logic [OPW-1:0] r_e_op;
  logic           r_m_wreg, r_m_reg2reg, r_m_wmem;
  logic [RW-1:0]  r_m_rd;
  logic           r_w_wreg, r_w_reg2reg;
  logic [RW-1:0]  r_w_rd;

  // Condep is active-low; a squash overrides a simultaneous stall because the
  // stalled D instruction is on the wrong path anyway.
  assign w_squash    = ~Condep;
  assign w_bubble_e  = w_squash | STALL;
  assign w_stall_evt = STALL & ~w_squash;

  // Front-end strobes: hold PC and IF/ID only on a real (unsquashed) stall.
  always_comb begin
    PcEn      = 1'b1;
    IfIdEn    = 1'b1;
    IfIdFlush = 1'b0;
    if (w_squash) begin
      IfIdFlush = 1'b1;
    end else if (STALL) begin
      PcEn   = 1'b0;
      IfIdEn = 1'b0;
    end
  end

  // E stage: take the D controls, or a bubble on stall/squash.
  always_ff @(posedge Clk) begin
    if (Rst || w_bubble_e) begin
      r_e_wreg    <= BUBBLE_WREG;
      r_e_reg2reg <= BUBBLE_REG2REG;
      r_e_wmem    <= BUBBLE_WMEM;
      r_e_rd      <= RW'(BUBBLE_RD);
      r_e_op      <= OPW'(BUBBLE_OP);
    end else begin
      r_e_wreg    <= dWreg;
      r_e_reg2reg <= dReg2reg;
      r_e_wmem    <= dWmem;
      r_e_rd      <= dRd;
      r_e_op      <= dOp;
    end
  end

  // M stage: unconditionally follows E.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_m_wreg    <= BUBBLE_WREG;
      r_m_reg2reg <= BUBBLE_REG2REG;
      r_m_wmem    <= BUBBLE_WMEM;
      r_m_rd      <= RW'(BUBBLE_RD);
    end else begin
      r_m_wreg    <= r_e_wreg;
      r_m_reg2reg <= r_e_reg2reg;
      r_m_wmem    <= r_e_wmem;
      r_m_rd      <= r_e_rd;
    end
  end

  // W stage: unconditionally follows M; the memory-write bit is no longer needed.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_w_wreg    <= BUBBLE_WREG;
      r_w_reg2reg <= BUBBLE_REG2REG;
      r_w_rd      <= RW'(BUBBLE_RD);
    end else begin
      r_w_wreg    <= r_m_wreg;
      r_w_reg2reg <= r_m_reg2reg;
      r_w_rd      <= r_m_rd;
    end
  end

  assign eWreg    = r_e_wreg;
  assign eReg2reg = r_e_reg2reg;
  assign eWmem    = r_e_wmem;
  assign eRd      = r_e_rd;
  assign eOp      = r_e_op;
  assign mWreg    = r_m_wreg;
  assign mReg2reg = r_m_reg2reg;
  assign mWmem    = r_m_wmem;
  assign mRd      = r_m_rd;
  assign wWreg    = r_w_wreg;
  assign wReg2reg = r_w_reg2reg;
  assign wRd      = r_w_rd;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk   (Clk),
    .i_srst  (Rst),
    .i_inc   (w_stall_evt),
    .o_count (StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk   (Clk),
    .i_srst  (Rst),
    .i_inc   (w_squash),
    .o_count (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// Directed bench for hazard_pipe_regs: a default-width instance plus a
// CNT_W=4 instance driven by the same inputs for the saturation check.
module tb_hazard_pipe_regs;

  logic       clk = 1'b0;
  logic       rst, stall, condep, d_wreg, d_reg2reg, d_wmem;
  logic [4:0] d_rd;
  logic [5:0] d_op;

  logic        e_wreg, e_reg2reg, e_wmem, m_wreg, m_reg2reg, m_wmem, w_wreg, w_reg2reg;
  logic [4:0]  e_rd, m_rd, w_rd;
  logic [5:0]  e_op;
  logic        pc_en, ifid_en, ifid_flush;
  logic [15:0] stall_cnt, flush_cnt;

  logic        n_e_wreg, n_e_reg2reg, n_e_wmem, n_m_wreg, n_m_reg2reg, n_m_wmem, n_w_wreg, n_w_reg2reg;
  logic [4:0]  n_e_rd, n_m_rd, n_w_rd;
  logic [5:0]  n_e_op;
  logic        n_pc_en, n_ifid_en, n_ifid_flush;
  logic [3:0]  n_stall_cnt, n_flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_pipe_regs dut (
    .Clk(clk), .Rst(rst), .STALL(stall), .Condep(condep),
    .dWreg(d_wreg), .dReg2reg(d_reg2reg), .dWmem(d_wmem), .dRd(d_rd), .dOp(d_op),
    .eWreg(e_wreg), .eReg2reg(e_reg2reg), .eWmem(e_wmem), .eRd(e_rd), .eOp(e_op),
    .mWreg(m_wreg), .mReg2reg(m_reg2reg), .mWmem(m_wmem), .mRd(m_rd),
    .wWreg(w_wreg), .wReg2reg(w_reg2reg), .wRd(w_rd),
    .PcEn(pc_en), .IfIdEn(ifid_en), .IfIdFlush(ifid_flush),
    .StallCnt(stall_cnt), .FlushCnt(flush_cnt)
  );

  hazard_pipe_regs #(.CNT_W(4)) dut_n (
    .Clk(clk), .Rst(rst), .STALL(stall), .Condep(condep),
    .dWreg(d_wreg), .dReg2reg(d_reg2reg), .dWmem(d_wmem), .dRd(d_rd), .dOp(d_op),
    .eWreg(n_e_wreg), .eReg2reg(n_e_reg2reg), .eWmem(n_e_wmem), .eRd(n_e_rd), .eOp(n_e_op),
    .mWreg(n_m_wreg), .mReg2reg(n_m_reg2reg), .mWmem(n_m_wmem), .mRd(n_m_rd),
    .wWreg(n_w_wreg), .wReg2reg(n_w_reg2reg), .wRd(n_w_rd),
    .PcEn(n_pc_en), .IfIdEn(n_ifid_en), .IfIdFlush(n_ifid_flush),
    .StallCnt(n_stall_cnt), .FlushCnt(n_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic wreg, input logic r2r, input logic wmem,
                       input logic [4:0] rd, input logic [5:0] op);
    d_wreg = wreg; d_reg2reg = r2r; d_wmem = wmem; d_rd = rd; d_op = op;
  endtask

  task automatic check_strobes(input string tag, input logic pc, input logic en, input logic fl);
    #1;
    check({tag, ".PcEn"}, 32'(pc_en), 32'(pc));
    check({tag, ".IfIdEn"}, 32'(ifid_en), 32'(en));
    check({tag, ".IfIdFlush"}, 32'(ifid_flush), 32'(fl));
  endtask

  initial begin
    // Reset with junk on every input.
    rst = 1'b1; stall = 1'($urandom); condep = 1'($urandom);
    set_d(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 6'($urandom));
    tick();
    set_d(1'b1, 1'b0, 1'b1, 5'd31, 6'h3f);
    tick();
    check("rst.eWreg", 32'(e_wreg), 0);     check("rst.eReg2reg", 32'(e_reg2reg), 1);
    check("rst.eWmem", 32'(e_wmem), 0);     check("rst.eRd", 32'(e_rd), 0);
    check("rst.eOp", 32'(e_op), 0);         check("rst.mWreg", 32'(m_wreg), 0);
    check("rst.mReg2reg", 32'(m_reg2reg), 1); check("rst.mWmem", 32'(m_wmem), 0);
    check("rst.mRd", 32'(m_rd), 0);         check("rst.wWreg", 32'(w_wreg), 0);
    check("rst.wReg2reg", 32'(w_reg2reg), 1); check("rst.wRd", 32'(w_rd), 0);
    check("rst.StallCnt", 32'(stall_cnt), 0); check("rst.FlushCnt", 32'(flush_cnt), 0);

    // Plain ALU instruction flowing E -> M -> W.
    rst = 1'b0; stall = 1'b0; condep = 1'b1;
    set_d(1'b1, 1'b1, 1'b0, 5'd8, 6'd0);
    check_strobes("flow", 1, 1, 0);
    tick();
    check("flow.eRd", 32'(e_rd), 8); check("flow.eWreg", 32'(e_wreg), 1);
    set_d(1'b0, 1'b1, 1'b0, 5'd0, 6'd0);
    tick();
    check("flow.mRd", 32'(m_rd), 8); check("flow.mWreg", 32'(m_wreg), 1);
    check("flow.eRd_next", 32'(e_rd), 0);
    check_strobes("flow2", 1, 1, 0);
    tick();
    check("flow.wRd", 32'(w_rd), 8); check("flow.wWreg", 32'(w_wreg), 1);
    check("flow.wReg2reg", 32'(w_reg2reg), 1);

    // Load-use stall for one cycle, then the load is released into E.
    set_d(1'b1, 1'b0, 1'b0, 5'd9, 6'h23);
    stall = 1'b1;
    check_strobes("stall", 0, 0, 0);
    tick();
    check("stall.eRd", 32'(e_rd), 0); check("stall.eWreg", 32'(e_wreg), 0);
    check("stall.eReg2reg", 32'(e_reg2reg), 1); check("stall.eOp", 32'(e_op), 0);
    check("stall.StallCnt", 32'(stall_cnt), 1);
    stall = 1'b0;
    tick();
    check("release.eRd", 32'(e_rd), 9); check("release.eReg2reg", 32'(e_reg2reg), 0);
    check("release.eOp", 32'(e_op), 32'h23);

    // Squash: wrong-path instruction in D becomes a bubble.
    condep = 1'b0;
    set_d(1'b1, 1'b1, 1'b0, 5'd12, 6'd0);
    check_strobes("squash", 1, 1, 1);
    tick();
    check("squash.eRd", 32'(e_rd), 0); check("squash.eWreg", 32'(e_wreg), 0);
    check("squash.FlushCnt", 32'(flush_cnt), 1); check("squash.StallCnt", 32'(stall_cnt), 1);
    check("squash.mRd", 32'(m_rd), 9);

    // Stall and squash together: squash wins.
    stall = 1'b1;
    check_strobes("both", 1, 1, 1);
    tick();
    check("both.eRd", 32'(e_rd), 0); check("both.eWreg", 32'(e_wreg), 0);
    check("both.FlushCnt", 32'(flush_cnt), 2); check("both.StallCnt", 32'(stall_cnt), 1);

    // Store: Wmem travels E -> M.
    stall = 1'b0; condep = 1'b1;
    set_d(1'b0, 1'b1, 1'b1, 5'd0, 6'h2b);
    tick();
    check("store.eWmem", 32'(e_wmem), 1); check("store.eOp", 32'(e_op), 32'h2b);
    set_d(1'b0, 1'b1, 1'b0, 5'd0, 6'd0);
    tick();
    check("store.mWmem", 32'(m_wmem), 1); check("store.eWmem_next", 32'(e_wmem), 0);

    // Long stall: 4-bit counter saturates, 16-bit one keeps counting.
    stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("sat.n_StallCnt", 32'(n_stall_cnt), 15);
    check("sat.StallCnt", 32'(stall_cnt), 21);
    check("sat.n_FlushCnt", 32'(n_flush_cnt), 2);
    tick();
    check("sat.n_StallCnt_hold", 32'(n_stall_cnt), 15);

    // Reset pulse clears the counters.
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0;
    check("rst2.n_StallCnt", 32'(n_stall_cnt), 0);
    check("rst2.StallCnt", 32'(stall_cnt), 0);
    check("rst2.FlushCnt", 32'(flush_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_pipe_regs.md
Name: hazard_pipe_regs

Overview:
- Receives the control unit's STALL/Condep decisions.
- Holds the E, M and W stage control registers whose contents (eRd, eWreg, eReg2reg, eOp, mRd, mWreg) are fed back to the control unit for forwarding and hazard detection.
- Generates PC and IF/ID enable and flush strobes, inserts E-stage bubbles, and keeps saturating stall/flush event counters.
- Sits between the decode stage and the datapath pipeline registers.

Parameters:
- RW, 5, register-specifier width.
- OPW, 6, opcode width.
- CNT_W, 16, width of each event counter.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- STALL  input  1  load-use stall request from the control unit.
- Condep  input  1  active-low squash: 0 means a taken branch or jump is in E.
- dWreg  input  1  D-stage register-write enable.
- dReg2reg  input  1  D-stage writeback select; 0 selects memory data (load).
- dWmem  input  1  D-stage memory-write enable.
- dRd  input  RW  D-stage destination register.
- dOp  input  OPW  D-stage opcode.
- eWreg, eReg2reg, eWmem  output  1  E-stage control bits.
- eRd  output  RW  E-stage destination register.
- eOp  output  OPW  E-stage opcode.
- mWreg, mReg2reg, mWmem  output  1  M-stage control bits.
- mRd  output  RW  M-stage destination register.
- wWreg, wReg2reg  output  1  W-stage control bits.
- wRd  output  RW  W-stage destination register.
- PcEn  output  1  PC load enable; combinational.
- IfIdEn  output  1  IF/ID register load enable; combinational.
- IfIdFlush  output  1  IF/ID clear to NOP; combinational.
- StallCnt  output  CNT_W  count of stall cycles.
- FlushCnt  output  CNT_W  count of squash cycles.

Behaviour:
- Reset: every registered output goes to 0, except eReg2reg, mReg2reg and wReg2reg, which reset to 1 (bubble encoding). StallCnt = FlushCnt = 0. Rst wins over all other inputs in the same cycle and discards any in-flight pipeline content.
- Bubble encoding: Wreg=0, Wmem=0, Reg2reg=1, Rd=0, Op=0. A bubble can never trigger forwarding or a stall, because Rd=0 and Wreg=0.
- Squash condition: squash = ~Condep.
- E register update, each edge:
  - If squash or STALL: load the bubble.
  - Otherwise: load dWreg, dReg2reg, dWmem, dRd, dOp.
- M register: always loads the E values; never stalled.
- W register: always loads the M values (Wmem is dropped).
- Latency: one cycle per stage. D inputs appear on e* one cycle later, on m* two cycles later, on w* three cycles later.
- Strobe generation (combinational, no registers):
  - squash=1: PcEn=1, IfIdEn=1, IfIdFlush=1 (branch target loads, wrong-path instruction is killed).
  - squash=0, STALL=1: PcEn=0, IfIdEn=0, IfIdFlush=0 (hold PC and IF/ID).
  - Neither: PcEn=1, IfIdEn=1, IfIdFlush=0.
- Simultaneous STALL and squash: squash dominates. The stall is dropped, since the stalled D instruction is wrong-path. Only FlushCnt increments.
- Counters:
  - StallCnt increments on a cycle with STALL=1 and squash=0.
  - FlushCnt increments on a cycle with squash=1.
  - Both saturate at 2^CNT_W-1 and never wrap. Both clear only on Rst.
- No combinational path from any d* input to any e*/m*/w* output. STALL/Condep reach only the strobes, so the control unit's feedback loop through eRd/eWreg is broken by a register.

Decomposition:
- Shared package (cpu_pkg) holds:
  - Opcode constants: OP_BEQ=6'b000100, OP_BNE=6'b000101, OP_J=6'b000010, OP_NOP=6'b000000.
  - Width constants RW and OPW.
  - Bubble field constants.
- One natural sub-module: sat_counter (CNT_W-wide, synchronous clear, increment-enable, saturation). Instantiate it twice.

Test Plan:
- Rst=1 for 2 cycles with random d*, STALL and Condep -> all outputs 0 except the three Reg2reg outputs = 1, and counters = 0.
- dRd=5'd8, dWreg=1, dReg2reg=1, dOp=0, STALL=0, Condep=1 -> eRd=8 after 1 edge, mRd=8 and mWreg=1 after 2 edges, wRd=8 after 3 edges; PcEn=1, IfIdEn=1, IfIdFlush=0 throughout.
- Load in D (dReg2reg=0, dRd=9), STALL=1 for one cycle with Condep=1 -> PcEn=0, IfIdEn=0 that cycle; E gets a bubble (eRd=0, eWreg=0, eReg2reg=1); StallCnt=1.
- Condep=0 with dRd=12, dWreg=1 -> IfIdFlush=1, PcEn=1; next cycle eRd=0, eWreg=0; FlushCnt=1.
- STALL=1 and Condep=0 in the same cycle -> PcEn=1, IfIdFlush=1, IfIdEn=1; E gets a bubble; FlushCnt increments and StallCnt is unchanged.
- CNT_W=4, STALL=1 held for 20 cycles with Condep=1 -> StallCnt reaches 15 and holds at 15; a following Rst pulse returns it to 0.
